// File: rtl/pq_ingress_if.sv
// pq_ingress_if: ingress, push and ID-release signals of pq_ingress
interface pq_ingress_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 3
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [DATA_WIDTH-1:0]        in_data_i;
  logic                         push_o;
  logic [DATA_WIDTH+ID_WIDTH-1:0] push_cell_o;
  logic                         push_ready_i;
  logic                         free_valid_i;
  logic [ID_WIDTH-1:0]          free_id_i;
  logic [ID_WIDTH-1:0]          occupancy_o;
  logic                         full_o;
  logic                         err_o;
  modport master (
    output in_valid_i, in_data_i, push_ready_i, free_valid_i, free_id_i,
    input  in_ready_o, push_o, push_cell_o, occupancy_o, full_o, err_o
  );
  modport slave (
    input  in_valid_i, in_data_i, push_ready_i, free_valid_i, free_id_i,
    output in_ready_o, push_o, push_cell_o, occupancy_o, full_o, err_o
  );
endinterface

// File: rtl/pq_ingress.sv
// pq_ingress: tags incoming data with the lowest free ID and stages it toward the priority queue
module pq_ingress #(
  parameter int QUEUE_DEPTH = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = $clog2(QUEUE_DEPTH) + 1
) (
  input logic         clk_i,
  input logic         rst_i,
  pq_ingress_if.slave bus
);
  localparam int N = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH-1:0] DEPTH = ID_WIDTH'(QUEUE_DEPTH);
  logic [N-1:0]                   r_map;
  logic [ID_WIDTH-1:0]            r_cnt;
  logic                           r_full;
  logic                           r_err;
  logic                           r_valid;
  logic [DATA_WIDTH+ID_WIDTH-1:0] r_cell;
  logic [ID_WIDTH-1:0]            w_id;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_free;
  logic [N-1:0]                   w_set;
  logic [N-1:0]                   w_clr;
  logic [ID_WIDTH-1:0]            w_cnt_nxt;
  always_comb begin
    w_id = '0;
    for (int k = N - 1; k >= 0; k--)
      if (!r_map[k]) w_id = ID_WIDTH'(k);
  end
  assign w_ready   = !rst_i && (r_cnt < DEPTH) && (!r_valid || bus.push_ready_i);
  assign w_accept  = bus.in_valid_i && w_ready;
  assign w_free    = bus.free_valid_i && r_map[bus.free_id_i];
  // the allocated bit is clear and the freed bit is set, so they never collide
  assign w_set     = w_accept ? N'(1) << w_id : '0;
  assign w_clr     = w_free ? N'(1) << bus.free_id_i : '0;
  assign w_cnt_nxt = r_cnt + ID_WIDTH'(w_accept) - ID_WIDTH'(w_free);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_map   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_cell  <= '0;
    end else begin
      r_map  <= (r_map | w_set) & ~w_clr;
      r_cnt  <= w_cnt_nxt;
      r_full <= w_cnt_nxt == DEPTH;
      r_err  <= bus.free_valid_i && !r_map[bus.free_id_i];
      if (w_accept) begin
        r_valid <= 1'b1;
        r_cell  <= {bus.in_data_i, w_id};
      end else if (bus.push_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready_o  = w_ready;
  assign bus.push_o      = r_valid;
  assign bus.push_cell_o = r_cell;
  assign bus.occupancy_o = r_cnt;
  assign bus.full_o      = r_full;
  assign bus.err_o       = r_err;
endmodule
